// File: rtl/dptr_sequencer.sv
`timescale 1ns/1ps
// dptr_sequencer: issue controller in front of the combinational DPTR R-type
// datapath. Buffers instruction words in a small FIFO and issues them one at a
// time. Each issued word is held on dptr_instr for a settle window, then the
// write strobe is pulsed. The block also latches the zero flag, counts retired
// instructions and keeps a sticky flag for illegal encodings.
module dptr_sequencer #(
  parameter int FIFO_DEPTH  = 4,   // power of two, >= 2
  parameter int EXEC_CYCLES = 2,   // >= 1
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic [31:0]      dptr_instr,
  output logic             dptr_we,
  input  logic             dptr_zf,
  output logic             busy,
  output logic             zf_q,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SET_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(EXEC_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(FIFO_DEPTH);

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

  // Only the R-type opcode with one of the five supported functs is legal.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    logic fn_ok;
    fn_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
            (funct == FN_OR)  || (funct == FN_SLT);
    return (op == 6'b000000) && fn_ok;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             full, empty;
  logic             push, pop;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);

  // A full FIFO refuses the push even when the FSM pops in the same cycle.
  // While rst_n is low the producer sees in_ready low.
  assign in_ready = rst_n && !full && !flush;
  assign push     = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [31:0]      dptr_instr_q, dptr_instr_d;
  logic             dptr_we_q, dptr_we_d;
  logic             zf_lat_q, zf_lat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  // Pointer and occupancy update; flush clears the queue outright.
  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Next-state and registered-output logic of the issue FSM.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    settle_d     = settle_q;
    dptr_instr_d = dptr_instr_q;
    dptr_we_d    = 1'b0;
    zf_lat_d     = zf_lat_q;
    retired_d    = retired_q;
    illegal_d    = illegal_q;
    pop          = 1'b0;

    if (flush) begin
      // Drop the in-flight instruction; status registers are left alone.
      state_d      = ST_IDLE;
      dptr_instr_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          dptr_instr_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            instr_d = mem[rd_ptr_q];
            state_d = ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (is_legal(instr_q[31:26], instr_q[5:0])) begin
            state_d      = ST_EXEC;
            settle_d     = SETTLE_INIT;
            dptr_instr_d = instr_q;
          end else begin
            illegal_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end

        ST_EXEC: begin
          if (settle_q == '0) begin
            state_d   = ST_WB;
            // rd == 0 retires without a register-bank write.
            dptr_we_d = (instr_q[15:11] != 5'd0);
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end

        ST_WB: begin
          zf_lat_d     = dptr_zf;
          retired_d    = retired_q + CNT_W'(1);
          dptr_instr_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            instr_d = mem[rd_ptr_q];
            state_d = ST_DECODE;
          end else begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Queue storage holds data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the reset occupancy of zero
    // guarantees stale entries are never read.
    if (push) mem[wr_ptr_q] <= in_instr;
  end

  // All control state, with an immediate return to reset values on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      settle_q     <= '0;
      dptr_instr_q <= '0;
      dptr_we_q    <= 1'b0;
      zf_lat_q     <= 1'b0;
      retired_q    <= '0;
      illegal_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      state_q      <= state_d;
      instr_q      <= instr_d;
      settle_q     <= settle_d;
      dptr_instr_q <= dptr_instr_d;
      dptr_we_q    <= dptr_we_d;
      zf_lat_q     <= zf_lat_d;
      retired_q    <= retired_d;
      illegal_q    <= illegal_d;
    end
  end

  assign dptr_instr = dptr_instr_q;
  assign dptr_we    = dptr_we_q;
  assign zf_q       = zf_lat_q;
  assign retired    = retired_q;
  assign illegal    = illegal_q;
  assign busy       = (state_q != ST_IDLE) || !empty;

  // The write strobe only ever accompanies the writeback state.
  a_we_only_in_wb: assert property (@(posedge clk) disable iff (!rst_n)
    dptr_we_q |-> (state_q == ST_WB));

  // Occupancy never exceeds the queue depth.
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ_q <= OCC_FULL);

  // The FSM never pops an empty queue.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> !empty);

endmodule

// File: tb/tb_dptr_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for dptr_sequencer. The bench owns a behavioural DPTR
// (register bank + ALU) that drives dptr_zf and takes the write strobe.
module tb_dptr_sequencer;

  localparam int FIFO_DEPTH  = 4;
  localparam int EXEC_CYCLES = 2;
  localparam int CNT_W       = 16;
  localparam int LAT         = EXEC_CYCLES + 3; // accept-cycle to WB-cycle distance
  localparam int PERIOD      = EXEC_CYCLES + 2; // back-to-back WB spacing

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_instr = '0;
  logic             in_ready;
  logic [31:0]      dptr_instr;
  logic             dptr_we;
  logic             dptr_zf;
  logic             busy;
  logic             zf_q;
  logic [CNT_W-1:0] retired;
  logic             illegal;

  always #5 clk = ~clk;

  dptr_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .EXEC_CYCLES(EXEC_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .dptr_instr(dptr_instr),
    .dptr_we   (dptr_we),
    .dptr_zf   (dptr_zf),
    .busy      (busy),
    .zf_q      (zf_q),
    .retired   (retired),
    .illegal   (illegal)
  );

  // ---------------------------------------------------------------------------
  // Behavioural DPTR datapath
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] alu_f(input logic [5:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    case (fn)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic bit legal_f(input logic [31:0] w);
    return (w[31:26] == 6'd0) &&
           (w[5:0] inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  logic [31:0] regs [32];
  logic [31:0] dptr_res;
  logic        load_req = 1'b0;
  logic [4:0]  load_idx = '0;
  logic [31:0] load_val = '0;

  always_comb dptr_res = alu_f(dptr_instr[5:0], regs[dptr_instr[25:21]], regs[dptr_instr[20:16]]);
  assign dptr_zf = (dptr_res == 32'd0);

  always @(posedge clk) begin
    if (load_req) regs[load_idx] <= load_val;
    else if (dptr_we && dptr_instr[15:11] != 5'd0) regs[dptr_instr[15:11]] <= dptr_res;
  end

  // ---------------------------------------------------------------------------
  // Monitor: accepted words and write strobes, stamped with cycle index
  // ---------------------------------------------------------------------------
  typedef struct { logic [31:0] w; int c; } rec_t;
  rec_t acc_q[$];
  rec_t we_q[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_q.push_back('{w: in_instr, c: cyc});
      if (dptr_we) we_q.push_back('{w: dptr_instr, c: cyc});
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_reg(input logic [4:0] idx, input logic [31:0] val);
    load_req = 1'b1;
    load_idx = idx;
    load_val = val;
    tick();
    load_req = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: in_ready=0 for 200 cycles, required 1");
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_idle_timeout: busy=1 after 1000 cycles, required 0", tag);
    end
    tick();
  endtask

  task automatic clear_mon();
    acc_q.delete();
    we_q.delete();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn;
    logic [5:0] op;
    logic [4:0] rd;
    int kind = $urandom_range(0, 7);
    op = (kind == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
    case ($urandom_range(0, 4))
      0: fn = 6'b100000;
      1: fn = 6'b100010;
      2: fn = 6'b100100;
      3: fn = 6'b100101;
      default: fn = 6'b101010;
    endcase
    if (kind == 1) fn = 6'($urandom);
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    return {op, 5'($urandom), 5'($urandom), rd, 5'($urandom), fn};
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors: one instruction each, run to completion
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] instr;
    bit          exp_we;
    logic [4:0]  reg_idx;
    logic [31:0] exp_val;
    bit          exp_zf;
    int          exp_ret;
    bit          exp_ill;
  } vec_t;

  vec_t vecs[10];

  // Model of the sequencer's architectural status
  int exp_ret = 0;
  bit exp_ill = 1'b0;
  bit exp_zf  = 1'b0;

  logic [31:0] ref_regs [32];
  logic [31:0] exp_w[$];

  initial begin
    $display("dptr_sequencer bench start");

    // ---------------- Reset values ----------------
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_dptr_we", dptr_we, 0);
    check("rst_dptr_instr", dptr_instr, 0);
    check("rst_zf", zf_q, 0);
    check("rst_retired", retired, 0);
    check("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    tick();

    // ---------------- Directed table ----------------
    for (int i = 0; i < 32; i++) load_reg(5'(i), 32'd0);
    load_reg(5'd2, 32'd123);
    load_reg(5'd3, 32'd456);
    load_reg(5'd5, 32'd5);
    load_reg(5'd6, 32'hFFFF_FFFD);
    load_reg(5'd7, 32'd233);
    load_reg(5'd8, 32'd233);

    vecs[0] = '{mk(6'd0, 5'd2, 5'd3, 5'd1,  6'b100000), 1, 5'd1,  32'd579, 0, 1, 0};
    vecs[1] = '{mk(6'd0, 5'd7, 5'd8, 5'd4,  6'b100010), 1, 5'd4,  32'd0,   1, 2, 0};
    vecs[2] = '{mk(6'd0, 5'd2, 5'd3, 5'd9,  6'b100101), 1, 5'd9,  32'd507, 0, 3, 0};
    vecs[3] = '{mk(6'd0, 5'd2, 5'd3, 5'd10, 6'b100100), 1, 5'd10, 32'd72,  0, 4, 0};
    vecs[4] = '{mk(6'd0, 5'd6, 5'd5, 5'd11, 6'b101010), 1, 5'd11, 32'd1,   0, 5, 0};
    vecs[5] = '{mk(6'd0, 5'd5, 5'd6, 5'd12, 6'b101010), 1, 5'd12, 32'd0,   1, 6, 0};
    vecs[6] = '{mk(6'd0, 5'd7, 5'd8, 5'd13, 6'b100010), 1, 5'd13, 32'd0,   1, 7, 0};
    vecs[7] = '{mk(6'b000010, 5'd2, 5'd3, 5'd14, 6'b100000), 0, 5'd14, 32'd0, 1, 7, 1};
    vecs[8] = '{mk(6'd0, 5'd2, 5'd3, 5'd15, 6'b000111), 0, 5'd15, 32'd0,   1, 7, 1};
    vecs[9] = '{mk(6'd0, 5'd2, 5'd3, 5'd0,  6'b100000), 0, 5'd0,  32'd0,   0, 8, 1};

    for (int i = 0; i < 10; i++) begin
      clear_mon();
      push(vecs[i].instr);
      wait_idle($sformatf("row%0d", i));
      check($sformatf("row%0d_we_count", i), we_q.size(), vecs[i].exp_we);
      if (vecs[i].exp_we && we_q.size() > 0 && acc_q.size() > 0) begin
        check($sformatf("row%0d_we_latency", i), we_q[0].c - acc_q[0].c, LAT);
        check($sformatf("row%0d_we_instr", i), we_q[0].w, vecs[i].instr);
      end
      check($sformatf("row%0d_reg", i), regs[vecs[i].reg_idx], vecs[i].exp_val);
      check($sformatf("row%0d_zf", i), zf_q, vecs[i].exp_zf);
      check($sformatf("row%0d_retired", i), retired, vecs[i].exp_ret);
      check($sformatf("row%0d_illegal", i), illegal, vecs[i].exp_ill);
      check($sformatf("row%0d_idle_instr", i), dptr_instr, 0);
      exp_ret = vecs[i].exp_ret;
      exp_ill = vecs[i].exp_ill;
      exp_zf  = vecs[i].exp_zf;
    end

    // ---------------- Back-to-back, valid held high ----------------
    begin
      logic [31:0] b2b [5];
      b2b[0] = mk(6'd0, 5'd2, 5'd3, 5'd16, 6'b100000);
      b2b[1] = mk(6'd0, 5'd7, 5'd8, 5'd17, 6'b100010);
      b2b[2] = mk(6'd0, 5'd2, 5'd3, 5'd18, 6'b100101);
      b2b[3] = mk(6'd0, 5'd2, 5'd3, 5'd19, 6'b100100);
      b2b[4] = mk(6'd0, 5'd6, 5'd5, 5'd20, 6'b101010);
      clear_mon();
      for (int i = 0; i < 5; i++) push(b2b[i]);
      @(negedge clk);
      check("b2b_full_in_ready", in_ready, 0);
      check("b2b_full_busy", busy, 1);
      tick();
      wait_idle("b2b");
      check("b2b_we_count", we_q.size(), 5);
      if (we_q.size() == 5 && acc_q.size() == 5) begin
        check("b2b_first_latency", we_q[0].c - acc_q[0].c, LAT);
        for (int i = 0; i < 5; i++) check($sformatf("b2b_order%0d", i), we_q[i].w, b2b[i]);
        for (int i = 1; i < 5; i++) check($sformatf("b2b_spacing%0d", i), we_q[i].c - we_q[i-1].c, PERIOD);
      end
      exp_ret += 5;
      exp_zf = 1'b0;
      check("b2b_retired", retired, CNT_W'(exp_ret));
      check("b2b_illegal", illegal, exp_ill);
      check("b2b_zf", zf_q, exp_zf);
      check("b2b_r16", regs[16], 32'd579);
      check("b2b_r17", regs[17], 32'd0);
    end

    // ---------------- Flush mid-EXEC with 3 queued ----------------
    clear_mon();
    for (int i = 0; i < 4; i++) push(mk(6'd0, 5'd2, 5'd3, 5'(22 + i), 6'b100000));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = mk(6'd0, 5'd2, 5'd3, 5'd27, 6'b100000);
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("flush_busy_before", busy, 1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_busy_after", busy, 0);
    check("flush_dptr_we", dptr_we, 0);
    check("flush_dptr_instr", dptr_instr, 0);
    check("flush_retired", retired, CNT_W'(exp_ret));
    check("flush_zf", zf_q, exp_zf);
    check("flush_illegal", illegal, exp_ill);
    repeat (8) tick();
    check("flush_no_we", we_q.size(), 0);
    check("flush_r22_untouched", regs[22], 32'd0);
    check("flush_r27_untouched", regs[27], 32'd0);
    clear_mon();
    push(mk(6'd0, 5'd2, 5'd3, 5'd26, 6'b100000));
    wait_idle("post_flush");
    exp_ret += 1;
    check("post_flush_we_count", we_q.size(), 1);
    check("post_flush_r26", regs[26], 32'd579);
    check("post_flush_retired", retired, CNT_W'(exp_ret));

    // ---------------- Randomized run against transaction model ----------------
    for (int i = 1; i < 32; i++)
      load_reg(5'(i), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom));
    for (int i = 0; i < 32; i++) ref_regs[i] = regs[i];
    clear_mon();
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push(rand_instr());
    end
    wait_idle("rand");

    exp_w.delete();
    foreach (acc_q[k]) begin
      logic [31:0] w;
      logic [31:0] r;
      w = acc_q[k].w;
      if (legal_f(w)) begin
        r = alu_f(w[5:0], ref_regs[w[25:21]], ref_regs[w[20:16]]);
        if (w[15:11] != 5'd0) begin
          ref_regs[w[15:11]] = r;
          exp_w.push_back(w);
        end
        exp_zf = (r == 32'd0);
        exp_ret++;
      end else begin
        exp_ill = 1'b1;
      end
    end
    check("rand_accepted", acc_q.size(), 60);
    check("rand_we_count", we_q.size(), exp_w.size());
    begin
      int bad_order = 0;
      int bad_gap   = 0;
      int bad_reg   = 0;
      for (int k = 0; k < we_q.size() && k < exp_w.size(); k++)
        if (we_q[k].w !== exp_w[k]) bad_order++;
      for (int k = 1; k < we_q.size(); k++)
        if (we_q[k].c - we_q[k-1].c < PERIOD) bad_gap++;
      for (int k = 0; k < 32; k++)
        if (regs[k] !== ref_regs[k]) bad_reg++;
      check("rand_we_order_errors", bad_order, 0);
      check("rand_we_gap_errors", bad_gap, 0);
      check("rand_regfile_errors", bad_reg, 0);
    end
    check("rand_retired", retired, CNT_W'(exp_ret));
    check("rand_illegal", illegal, exp_ill);
    check("rand_zf", zf_q, exp_zf);

    // ---------------- Async reset during WB ----------------
    load_reg(5'd2, 32'd123);
    load_reg(5'd3, 32'd456);
    load_reg(5'd21, 32'hDEAD_BEEF);
    push(mk(6'd0, 5'd2, 5'd3, 5'd21, 6'b100000));
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge clk);
        if (dptr_we) seen = 1'b1;
      end
      check("rst_wb_reached", seen, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_dptr_we", dptr_we, 0);
    check("arst_dptr_instr", dptr_instr, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_retired", retired, 0);
    check("arst_illegal", illegal, 0);
    check("arst_zf", zf_q, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_no_partial_wb", regs[21], 32'hDEAD_BEEF);
    check("arst_release_retired", retired, 0);
    check("arst_release_in_ready", in_ready, 1);
    tick();
    push(mk(6'd0, 5'd2, 5'd3, 5'd21, 6'b100000));
    wait_idle("post_reset");
    check("post_reset_retired", retired, 1);
    check("post_reset_r21", regs[21], 32'd579);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop if the run wedges somewhere unbounded.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
